register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Operand register file feeding the ALU A/B inputs: four general registers R1-R4 and
//  four scratch registers S1-S4, all 32-bit. The write path takes I (ALUOut via the
//  datapath mux, or an immediate) and applies a per-cycle function (load, inc/dec,
//  clear, partial/byte writes). Two independent read muxes drive OutA/OutB to ALU A/B.
// PARAMETERS
//  DATA_W   32  register and port width; FunSel byte/half modes assume DATA_W=32
//  NUM_GP   4   general registers R1..R4 (fixed; RegSel width tracks it)
//  NUM_SCR  4   scratch registers S1..S4 (fixed; ScrSel width tracks it)
// PORTS
//  Clock    in   1   rising-edge clock, only clock domain
//  Reset    in   1   synchronous, active-low; clears all registers
//  I        in   32  write data
//  FunSel   in   3   write function, applied to every enabled register
//  RegSel   in   4   write enable, R1..R4 (bit0=R1, bit3=R4), active-high
//  ScrSel   in   4   write enable, S1..S4 (bit0=S1, bit3=S4), active-high
//  OutASel  in   3   OutA source: 000-011 = R1-R4, 100-111 = S1-S4
//  OutBSel  in   3   OutB source, same encoding
//  OutA     out  32  to ALU A
//  OutB     out  32  to ALU B
// BEHAVIOUR
//  Reset: Reset==0 at a rising Clock edge sets R1-R4 and S1-S4 to 32'h0.
//   Reset takes priority over any write that cycle. OutA/OutB then show 0.
//  Write: one rising-edge update per cycle. Each register whose Sel bit is 1 is
//   updated per FunSel. Registers with Sel bit 0 hold. RegSel=ScrSel=0 is a no-op.
//  FunSel, Q = current value, Q' = next value:
//   000 DEC   Q' = Q - 1, 32-bit wrap (0 -> 32'hFFFF_FFFF), no flag output
//   001 INC   Q' = Q + 1, 32-bit wrap (32'hFFFF_FFFF -> 0)
//   010 LOAD  Q' = I
//   011 CLR   Q' = 0
//   100 LDB   Q' = {24'h0, I[7:0]}
//   101 LDH   Q' = {Q[31:16], I[15:0]}       (upper half preserved)
//   110 SHB   Q' = {Q[23:0], I[7:0]}         (shift left one byte, append I byte)
//   111 SXH   Q' = {{16{I[15]}}, I[15:0]}    (sign-extend halfword)
//  Several Sel bits high: every selected register applies the same FunSel to its
//   own Q independently. Example: INC with R1=5, S2=9 gives R1=6, S2=10.
//  Read: OutA/OutB are combinational muxes of the register outputs.
//   Zero-cycle read latency and no write bypass: a register written in cycle n
//   shows the new value on OutA/OutB only after the edge that ends cycle n.
//   OutASel==OutBSel is legal; both outputs carry the same value.
//  Read-modify-write in one cycle is legal and expected. The datapath routes
//   R1 -> ALU -> I -> R1, and R1 updates once, at the edge.
//  Reset mid-operation, e.g. mid INC sequence: the next edge clears everything.
//   The sequence then restarts from 0 after Reset returns to 1.
//  No X propagation: FunSel is fully decoded and has no default hold case.
// TESTING
//  1 Reset=0 for one edge with RegSel=ScrSel=4'hF, FunSel=010, I=32'hDEAD_BEEF
//    -> all 8 registers read 0 (reset beats write).
//  2 LOAD R3 with I=32'h1234_5678, then OutASel=010, OutBSel=010
//    -> OutA=OutB=32'h1234_5678. In the write cycle itself OutA still showed 0.
//  3 S1=32'hFFFF_FFFF, INC -> 0. Then DEC -> 32'hFFFF_FFFF. R2=0, DEC
//    -> 32'hFFFF_FFFF (both wrap directions).
//  4 R4=32'hAABB_CCDD:
//    LDH with I=32'h0000_1122 -> 32'hAABB_1122
//    SHB with I=8'h33 -> 32'hBB11_2233
//    LDB with I=8'h44 -> 32'h0000_0044
//    SXH with I=16'h8001 -> 32'hFFFF_8001
//  5 RegSel=4'b0101, ScrSel=4'b1000, FunSel=011 with all registers preset nonzero
//    -> R1, R3, S4 = 0. R2, R4, S1-S3 unchanged.
//  6 Loop R1 -> OutA, I=OutA+1 (external), LOAD R1 five cycles from 0
//    -> R1=5. Assert Reset in cycle 3 -> R1=0 at that edge, counting resumes from 0.

Source files
------------

// File: rtl/register_file.sv
// rtl/register_file.sv - operand register file, R1-R4 and S1-S4 with per-cycle write functions
module register_file #(
    parameter int DATA_W  = 32,
    parameter int NUM_GP  = 4,
    parameter int NUM_SCR = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] I,
    input  logic [2:0]        FunSel,
    input  logic [NUM_GP-1:0] RegSel,
    input  logic [NUM_SCR-1:0] ScrSel,
    input  logic [2:0]        OutASel,
    input  logic [2:0]        OutBSel,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB
);

    typedef enum logic [2:0] {
        FN_DEC  = 3'b000,
        FN_INC  = 3'b001,
        FN_LOAD = 3'b010,
        FN_CLR  = 3'b011,
        FN_LDB  = 3'b100,
        FN_LDH  = 3'b101,
        FN_SHB  = 3'b110,
        FN_SXH  = 3'b111
    } fun_t;

    logic [DATA_W-1:0] gp  [NUM_GP];
    logic [DATA_W-1:0] scr [NUM_SCR];

    // Next value of one register under the selected function; every encoding is listed
    function automatic logic [DATA_W-1:0] apply_fun(
        input logic [DATA_W-1:0] q,
        input logic [DATA_W-1:0] d,
        input logic [2:0]        fs
    );
        logic [DATA_W-1:0] r;
        r = q;
        case (fun_t'(fs))
            FN_DEC:  r = q - 1'b1;
            FN_INC:  r = q + 1'b1;
            FN_LOAD: r = d;
            FN_CLR:  r = '0;
            FN_LDB:  r = {24'h0, d[7:0]};
            FN_LDH:  r = {q[31:16], d[15:0]};
            FN_SHB:  r = {q[23:0], d[7:0]};
            FN_SXH:  r = {{16{d[15]}}, d[15:0]};
        endcase
        return r;
    endfunction

    // General registers: reset wins, otherwise each enabled register updates from its own value
    always_ff @(posedge Clock) begin
        for (int k = 0; k < NUM_GP; k++) begin
            if (!Reset) begin
                gp[k] <= '0;
            end else if (RegSel[k]) begin
                gp[k] <= apply_fun(gp[k], I, FunSel);
            end
        end
    end

    // Scratch registers: same write behaviour, independent enables
    always_ff @(posedge Clock) begin
        for (int k = 0; k < NUM_SCR; k++) begin
            if (!Reset) begin
                scr[k] <= '0;
            end else if (ScrSel[k]) begin
                scr[k] <= apply_fun(scr[k], I, FunSel);
            end
        end
    end

    // Port A read mux: no bypass, shows the registered value
    always_comb begin
        OutA = '0;
        if (OutASel[2]) begin
            OutA = scr[OutASel[1:0]];
        end else begin
            OutA = gp[OutASel[1:0]];
        end
    end

    // Port B read mux, identical encoding to port A
    always_comb begin
        OutB = '0;
        if (OutBSel[2]) begin
            OutB = scr[OutBSel[1:0]];
        end else begin
            OutB = gp[OutBSel[1:0]];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

    logic        Clock;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [31:0] OutA;
    logic [31:0] OutB;

    int errors = 0;
    int checks = 0;

    register_file dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One write cycle, then enables drop; samples happen 1ns after the edge
    task automatic wr(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                      input logic [31:0] d);
        FunSel = fs;
        RegSel = rs;
        ScrSel = ss;
        I      = d;
        @(posedge Clock);
        #1;
        RegSel = 4'h0;
        ScrSel = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        OutASel = sel;
        OutBSel = sel;
        #1;
        chk({tag, "_a"}, OutA, exp);
        chk({tag, "_b"}, OutB, exp);
    endtask

    initial begin
        logic [31:0] pre [8];
        logic [31:0] model;

        Reset = 1'b1; I = '0; FunSel = 3'b000; RegSel = 4'h0; ScrSel = 4'h0;
        OutASel = 3'd0; OutBSel = 3'd0;
        #2;

        // 1: reset beats a full-width LOAD
        Reset = 1'b0;
        wr(3'b010, 4'hF, 4'hF, 32'hDEAD_BEEF);
        Reset = 1'b1;
        for (int k = 0; k < 8; k++) rd($sformatf("reset_r%0d", k), 3'(k), 32'h0);

        // 2: LOAD R3, no bypass during the write cycle
        OutASel = 3'b010; OutBSel = 3'b010;
        FunSel = 3'b010; RegSel = 4'b0100; I = 32'h1234_5678;
        #1;
        chk("load_r3_prewrite", OutA, 32'h0);
        @(posedge Clock); #1;
        RegSel = 4'h0;
        chk("load_r3_a", OutA, 32'h1234_5678);
        chk("load_r3_b", OutB, 32'h1234_5678);

        // 3: wrap in both directions
        wr(3'b010, 4'h0, 4'b0001, 32'hFFFF_FFFF);
        wr(3'b001, 4'h0, 4'b0001, 32'h0);
        rd("s1_inc_wrap", 3'b100, 32'h0);
        wr(3'b000, 4'h0, 4'b0001, 32'h0);
        rd("s1_dec_wrap", 3'b100, 32'hFFFF_FFFF);
        wr(3'b000, 4'b0010, 4'h0, 32'h0);
        rd("r2_dec_wrap", 3'b001, 32'hFFFF_FFFF);

        // 4: partial and byte writes on R4
        wr(3'b010, 4'b1000, 4'h0, 32'hAABB_CCDD);
        wr(3'b101, 4'b1000, 4'h0, 32'h0000_1122);
        rd("r4_ldh", 3'b011, 32'hAABB_1122);
        wr(3'b110, 4'b1000, 4'h0, 32'h0000_0033);
        rd("r4_shb", 3'b011, 32'hBB11_2233);
        wr(3'b100, 4'b1000, 4'h0, 32'hFFFF_FF44);
        rd("r4_ldb", 3'b011, 32'h0000_0044);
        wr(3'b111, 4'b1000, 4'h0, 32'h0000_8001);
        rd("r4_sxh", 3'b011, 32'hFFFF_8001);

        // 5: multi-select CLR with everything preset nonzero
        pre = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};
        for (int k = 0; k < 4; k++) wr(3'b010, 4'(1 << k), 4'h0, pre[k]);
        for (int k = 0; k < 4; k++) wr(3'b010, 4'h0, 4'(1 << k), pre[k + 4]);
        wr(3'b011, 4'b0101, 4'b1000, 32'hFFFF_FFFF);
        rd("clr_r1", 3'd0, 32'h0);
        rd("clr_r2", 3'd1, 32'h2222_0002);
        rd("clr_r3", 3'd2, 32'h0);
        rd("clr_r4", 3'd3, 32'h4444_0004);
        rd("clr_s1", 3'd4, 32'h5555_0005);
        rd("clr_s2", 3'd5, 32'h6666_0006);
        rd("clr_s3", 3'd6, 32'h7777_0007);
        rd("clr_s4", 3'd7, 32'h0);

        // multi-select INC on independent values, with OutA/OutB on different registers
        wr(3'b010, 4'b0001, 4'h0, 32'd5);
        wr(3'b010, 4'h0, 4'b0010, 32'd9);
        wr(3'b001, 4'b0001, 4'b0010, 32'h0);
        OutASel = 3'd0; OutBSel = 3'd5; #1;
        chk("multi_inc_r1", OutA, 32'd6);
        chk("multi_inc_s2", OutB, 32'd10);

        // 6: external read-modify-write loop through R1
        wr(3'b011, 4'b0001, 4'h0, 32'h0);
        OutASel = 3'd0; OutBSel = 3'd0;
        for (int c = 0; c < 5; c++) begin
            #1;
            wr(3'b010, 4'b0001, 4'h0, OutA + 32'd1);
        end
        #1;
        chk("rmw_loop_r1", OutA, 32'd5);

        wr(3'b011, 4'b0001, 4'h0, 32'h0);
        model = 32'd0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            Reset = (c == 3) ? 1'b0 : 1'b1;
            wr(3'b010, 4'b0001, 4'h0, OutA + 32'd1);
            Reset = 1'b1;
            model = (c == 3) ? 32'd0 : model + 32'd1;
            #1;
            chk($sformatf("rmw_reset_c%0d", c), OutA, model);
        end
        chk("rmw_reset_s3_cleared", dut.scr[2], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
